rom_arbiter: RTL and testbench

//  Shares one combinational-read program ROM between two requesters: instruction fetch (IF) and

---
 rtl/rom_arb_pkg.sv | 17 +
 rtl/rom_arb_resp_reg.sv | 49 ++++
 rtl/rom_arbiter.sv | 96 +++++++++
 tb/tb_rom_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and types for the two-port program ROM arbiter.
package rom_arb_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LD = 1'b1;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int RESP_DATA_W_DEF  = 32;

  // Response at the default word width; the response register builds its own at DATA_WIDTH.
  typedef struct packed {
    logic                       valid;
    logic                       err;
    logic [RESP_DATA_W_DEF-1:0] data;
  } rom_resp_t;

endpackage

// File: rtl/rom_arb_resp_reg.sv
// Per-port response register: captures ROM data on grant, pulses valid, holds data/err otherwise.
module rom_arb_resp_reg
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int ROM_DEPTH  = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_gnt,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  output logic                  o_rvalid,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  resp_t resp_q, resp_d;
  logic  oor;

  // One extra bit so ROM_DEPTH == 2**ADDR_WIDTH still compares correctly.
  assign oor = ({1'b0, i_addr} >= (ADDR_WIDTH+1)'(ROM_DEPTH));

  always_comb begin
    resp_d       = resp_q;
    resp_d.valid = i_gnt;
    if (i_gnt) begin
      resp_d.err  = oor;
      resp_d.data = oor ? '0 : i_rom_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) resp_q <= '0;
    else          resp_q <= resp_d;
  end

  assign o_rvalid = resp_q.valid;
  assign o_err    = resp_q.err;
  assign o_rdata  = resp_q.data;

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester (IF/LD) arbiter for a combinational-read ROM with registered responses.
// Optional LD anti-starvation counter enabled by defining ROM_ARB_STARVE_EN.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int ROM_DEPTH    = 256,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic                  o_if_gnt,
  output logic                  o_if_rvalid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic                  o_if_err,
  input  logic                  i_ld_req,
  input  logic [ADDR_WIDTH-1:0] i_ld_addr,
  output logic                  o_ld_gnt,
  output logic                  o_ld_rvalid,
  output logic [DATA_WIDTH-1:0] o_ld_rdata,
  output logic                  o_ld_err,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data
);

  logic ld_prio;
  logic sel;
  logic last_sel_q, last_sel_d;

`ifdef ROM_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT+1);
  logic [CW-1:0] starve_q, starve_d;

  assign ld_prio = (starve_q == CW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!i_ld_req || o_ld_gnt)                          starve_d = '0;
    else if (i_if_req && starve_q != CW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign ld_prio = 1'b0;
`endif

  // IF wins contention unless the starve counter has handed priority to LD.
  assign o_if_gnt = i_rst_n & i_if_req & ~(i_ld_req & ld_prio);
  assign o_ld_gnt = i_rst_n & i_ld_req & ~(i_if_req & ~ld_prio);

  assign sel        = o_ld_gnt ? PORT_LD : (o_if_gnt ? PORT_IF : last_sel_q);
  assign last_sel_d = sel;
  assign o_rom_addr = !i_rst_n ? '0 : ((sel == PORT_LD) ? i_ld_addr : i_if_addr);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) last_sel_q <= PORT_IF;
    else          last_sel_q <= last_sel_d;
  end

  rom_arb_resp_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROM_DEPTH  (ROM_DEPTH)
  ) u_resp_if (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_gnt      (o_if_gnt),
    .i_addr     (i_if_addr),
    .i_rom_data (i_rom_data),
    .o_rvalid   (o_if_rvalid),
    .o_err      (o_if_err),
    .o_rdata    (o_if_rdata)
  );

  rom_arb_resp_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ROM_DEPTH  (ROM_DEPTH)
  ) u_resp_ld (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_gnt      (o_ld_gnt),
    .i_addr     (i_ld_addr),
    .i_rom_data (i_rom_data),
    .o_rvalid   (o_ld_rvalid),
    .o_err      (o_ld_err),
    .o_rdata    (o_ld_rdata)
  );

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed + randomized bench for rom_arbiter against a cycle-level reference model.
module tb_rom_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 256;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, ld_req = 1'b0;
  logic [AW-1:0] if_addr = '0, ld_addr = '0;
  logic          if_gnt, ld_gnt, if_rvalid, ld_rvalid, if_err, ld_err;
  logic [DW-1:0] if_rdata, ld_rdata, rom_data;
  logic [AW-1:0] rom_addr;

  int errors = 0;
  int checks = 0;

  int      m_last = 0;
  int      m_loss = 0;
  bit      m_rv_if = 0, m_rv_ld = 0, m_er_if = 0, m_er_ld = 0;
  bit [31:0] m_rd_if = 0, m_rd_ld = 0;
  bit      got_if = 0, got_ld = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  rom_arbiter #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .ROM_DEPTH    (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_gnt    (if_gnt),
    .o_if_rvalid (if_rvalid),
    .o_if_rdata  (if_rdata),
    .o_if_err    (if_err),
    .i_ld_req    (ld_req),
    .i_ld_addr   (ld_addr),
    .o_ld_gnt    (ld_gnt),
    .o_ld_rvalid (ld_rvalid),
    .o_ld_rdata  (ld_rdata),
    .o_ld_err    (ld_err),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check grant/address mid-cycle, then check responses after the edge.
  task automatic cyc(input bit r, input bit iq, input int ia, input bit lq, input int la);
    bit eg_if, eg_ld;
    int ea;
    @(negedge clk);
    rst_n = r; if_req = iq; if_addr = AW'(ia); ld_req = lq; ld_addr = AW'(la);
    #1;
    if (!r) begin
      eg_if = 0; eg_ld = 0;
    end else if (iq && lq) begin
`ifdef ROM_ARB_STARVE_EN
      eg_ld = (m_loss >= LIMIT);
`else
      eg_ld = 0;
`endif
      eg_if = !eg_ld;
    end else begin
      eg_if = iq; eg_ld = lq;
    end
    if (!r)         ea = 0;
    else if (eg_ld) ea = la;
    else if (eg_if) ea = ia;
    else            ea = (m_last == 1) ? la : ia;
    chk("if_gnt", 64'(if_gnt), 64'(eg_if));
    chk("ld_gnt", 64'(ld_gnt), 64'(eg_ld));
    chk("rom_addr", 64'(rom_addr), 64'(ea));
    got_if = eg_if; got_ld = eg_ld;

    if (!r)         m_last = 0;
    else if (eg_ld) m_last = 1;
    else if (eg_if) m_last = 0;
    if (!r || !lq || eg_ld) m_loss = 0;
    else if (iq)            m_loss = (m_loss + 1 > LIMIT) ? LIMIT : m_loss + 1;

    if (!r) begin
      m_rv_if = 0; m_er_if = 0; m_rd_if = 0;
      m_rv_ld = 0; m_er_ld = 0; m_rd_ld = 0;
    end else begin
      m_rv_if = eg_if;
      if (eg_if) begin
        m_er_if = (ia >= DEPTH);
        m_rd_if = m_er_if ? 32'h0 : rom_fn(AW'(ia));
      end
      m_rv_ld = eg_ld;
      if (eg_ld) begin
        m_er_ld = (la >= DEPTH);
        m_rd_ld = m_er_ld ? 32'h0 : rom_fn(AW'(la));
      end
    end
    @(posedge clk);
    #1;
    chk("if_rvalid", 64'(if_rvalid), 64'(m_rv_if));
    chk("if_err",    64'(if_err),    64'(m_er_if));
    chk("if_rdata",  64'(if_rdata),  64'(m_rd_if));
    chk("ld_rvalid", 64'(ld_rvalid), 64'(m_rv_ld));
    chk("ld_err",    64'(ld_err),    64'(m_er_ld));
    chk("ld_rdata",  64'(ld_rdata),  64'(m_rd_ld));
  endtask

  initial begin
    bit iq, lq, r;
    int ia, la;

    // reset state
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 5, 1, 6);
    // IF-only reads 0,1,2 back to back, then idle
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 2, 0, 0);
    cyc(1, 0, 2, 0, 0);
    // contention: IF 0x10 vs LD 0x20
    for (int i = 0; i < 20; i++) cyc(1, 1, 'h10, 1, 'h20);
    cyc(1, 0, 'h10, 0, 'h20);
    // out-of-range LD and IF, plus the last in-range word
    cyc(1, 0, 0, 1, 256);
    cyc(1, 0, 0, 1, 255);
    cyc(1, 1, 511, 0, 255);
    cyc(1, 0, 511, 0, 255);
    // reset while an IF response is pending
    cyc(1, 1, 9, 0, 0);
    cyc(0, 0, 9, 0, 0);
    cyc(0, 0, 9, 0, 0);
    cyc(1, 1, 4, 0, 0);
    // alternating single requests with idle cycles holding the last address
    cyc(1, 1, 3, 0, 7);
    cyc(1, 0, 3, 1, 7);
    cyc(1, 0, 3, 0, 7);
    cyc(1, 0, 3, 0, 7);
    cyc(1, 1, 11, 0, 7);
    cyc(1, 0, 11, 0, 7);

    // random traffic honouring the hold-until-grant rule, with rare deassertion and reset
    iq = 0; lq = 0; ia = 0; la = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(iq && !got_if && $urandom_range(7) != 0)) begin
        iq = ($urandom_range(2) != 0);
        ia = $urandom_range(300);
      end
      if (!(lq && !got_ld && $urandom_range(7) != 0)) begin
        lq = ($urandom_range(2) != 0);
        la = $urandom_range(300);
      end
      r = ($urandom_range(40) != 0);
      cyc(r, iq, ia, lq, la);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
